// File: rtl/am_demod_pkg.sv
// am_demod_pkg: shared FSM states, mode encodings and latency figures for the AM envelope detector.
package am_demod_pkg;

    typedef enum logic [2:0] {IDLE, SQ_I, SQ_Q, SUM, ROOT, DONE} state_t;

    localparam logic MODE_POWER = 1'b0;
    localparam logic MODE_MAG   = 1'b1;

    localparam int POWER_LAT = 4;

    function automatic int mag_lat(input int w);
        return POWER_LAT + w;
    endfunction

endpackage

// File: rtl/iter_isqrt.sv
// iter_isqrt: non-restoring integer square root, one root bit per clock, MSB first.
module iter_isqrt #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
    input  logic [2*W-1:0] i_radicand,
    output logic           o_done,
    output logic [W-1:0]   o_root
);

    localparam int RW = W + 3;
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] r_rad;
    logic [RW-1:0]  r_rem;
    logic [W-1:0]   r_root;
    logic [CW-1:0]  r_cnt;
    logic [RW-1:0]  w_rem_sh;
    logic [RW-1:0]  w_rem_nxt;
    logic [W-1:0]   w_root_nxt;

    // Remainder sign picks add or subtract; its inverse is the next root bit.
    always_comb begin
        w_rem_sh   = {r_rem[RW-3:0], r_rad[2*W-1 -: 2]};
        w_rem_nxt  = r_rem[RW-1] ? w_rem_sh + RW'({r_root, 2'b11})
                                 : w_rem_sh - RW'({r_root, 2'b01});
        w_root_nxt = {r_root[W-2:0], ~w_rem_nxt[RW-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rad  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_rad  <= i_radicand;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= CW'(W);
        end else if (r_cnt != '0) begin
            r_rad  <= r_rad << 2;
            r_rem  <= w_rem_nxt;
            r_root <= w_root_nxt;
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    // The final root is presented combinationally during the last iteration cycle.
    assign o_done = (r_cnt == CW'(1));
    assign o_root = w_root_nxt;

endmodule

// File: rtl/am_envelope_detector.sv
// am_envelope_detector: I/Q power or envelope magnitude with one shared registered squarer
// and an iterative square root, qualified by a valid/ready handshake.
module am_envelope_detector
    import am_demod_pkg::*;
#(
    parameter int W     = 8,
    parameter int OUT_W = 2 * W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     i_in,
    input  logic [W-1:0]     q_in,
    input  logic             mode,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             drop_flag,
    input  logic             drop_clr
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_i;
    logic [W-1:0]     r_q;
    logic             r_mode;
    logic [2*W-1:0]   r_prod;
    logic [2*W-1:0]   r_isq;
    logic [OUT_W-1:0] r_out;
    logic             r_drop;
    logic             w_accept;
    logic [W-1:0]     w_op;
    logic [2*W-1:0]   w_opx;
    logic [2*W-1:0]   w_sum;
    logic             w_sq_start;
    logic             w_sq_done;
    logic [W-1:0]     w_root;

    assign in_ready   = (r_state == IDLE) || (r_state == DONE);
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = (r_state == DONE);
    assign out_data   = r_out;
    assign drop_flag  = r_drop;
    assign w_sq_start = (r_state == SUM) && (r_mode == MODE_MAG);

    // Sign-extended operand; the low 2W bits of the product are the square.
    assign w_op  = (r_state == SQ_I) ? r_i : r_q;
    assign w_opx = {{W{w_op[W-1]}}, w_op};
    assign w_sum = r_isq + r_prod;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_accept ? SQ_I : IDLE;
            SQ_I:    w_state_nxt = SQ_Q;
            SQ_Q:    w_state_nxt = SUM;
            SUM:     w_state_nxt = (r_mode == MODE_MAG) ? ROOT : DONE;
            ROOT:    w_state_nxt = w_sq_done ? DONE : ROOT;
            DONE:    w_state_nxt = w_accept ? SQ_I : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i    <= '0;
            r_q    <= '0;
            r_mode <= MODE_POWER;
            r_prod <= '0;
            r_isq  <= '0;
            r_out  <= '0;
            r_drop <= 1'b0;
        end else begin
            if (w_accept) begin
                r_i    <= i_in;
                r_q    <= q_in;
                r_mode <= mode;
            end
            r_prod <= w_opx * w_opx;
            if (r_state == SQ_Q) r_isq <= r_prod;
            // Result lands on the edge entering DONE so it is visible with out_valid.
            if ((r_state == SUM) && (r_mode == MODE_POWER)) r_out <= OUT_W'(w_sum);
            else if ((r_state == ROOT) && w_sq_done)        r_out <= OUT_W'(w_root);
            r_drop <= (in_valid && !in_ready) || (r_drop && !drop_clr);
        end
    end

    iter_isqrt #(.W(W)) u_isqrt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_sq_start),
        .i_radicand (w_sum),
        .o_done     (w_sq_done),
        .o_root     (w_root)
    );

endmodule

// File: tb/tb_am_envelope_detector.sv
// tb_am_envelope_detector: directed checks of latency, results, drop handling, back-to-back and reset.
module tb_am_envelope_detector;
    import am_demod_pkg::*;

    localparam int W     = 8;
    localparam int OUT_W = 2 * W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             mode = 1'b0;
    logic             drop_clr = 1'b0;
    logic [W-1:0]     i_in = '0;
    logic [W-1:0]     q_in = '0;
    logic             in_ready;
    logic             out_valid;
    logic             drop_flag;
    logic [OUT_W-1:0] out_data;
    int               n_tests = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;

    am_envelope_detector #(.W(W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_in      (i_in),
        .q_in      (q_in),
        .mode      (mode),
        .out_valid (out_valid),
        .out_data  (out_data),
        .drop_flag (drop_flag),
        .drop_clr  (drop_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_out(input int start, output int lat);
        lat = start;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic count_out(input int cycles, output int cnt);
        cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) cnt++;
        end
    endtask

    task automatic run(input string tag, input int i, input int q, input logic m,
                       input int exp_data, input int exp_lat);
        int lat;
        @(negedge clk);
        i_in = W'(i);
        q_in = W'(q);
        mode = m;
        in_valid = 1'b1;
        chk({tag, "_rdy"}, 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        mode = ~m;
        chk({tag, "_busy"}, 32'(in_ready), 0);
        wait_out(1, lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, 32'(out_data), exp_data);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(out_valid), 0);
        chk({tag, "_hold"}, 32'(out_data), exp_data);
    endtask

    initial begin
        int lat;
        int cnt;
        int k;
        int acc;
        int last_acc;
        int got;
        int ii;
        int qq;
        logic took;
        int exp_q[$];

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_drop", 32'(drop_flag), 0);
        rst_n = 1'b1;

        run("pw_3_4", 3, 4, MODE_POWER, 25, POWER_LAT);
        run("mg_3_4", 3, 4, MODE_MAG, 5, mag_lat(W));
        run("pw_min", -128, -128, MODE_POWER, 32768, POWER_LAT);
        run("mg_min", -128, -128, MODE_MAG, 181, mag_lat(W));
        run("pw_zero", 0, 0, MODE_POWER, 0, POWER_LAT);
        run("mg_zero", 0, 0, MODE_MAG, 0, mag_lat(W));
        run("mg_m1", -1, 0, MODE_MAG, 1, mag_lat(W));
        run("pw_max", 127, 127, MODE_POWER, 32258, POWER_LAT);
        run("mg_mix", -7, 100, MODE_MAG, 100, mag_lat(W));
        run("pw_mix", 5, -3, MODE_POWER, 34, POWER_LAT);

        // Drops at A+2 and A+5 while a magnitude sample is in flight
        @(negedge clk);
        i_in = 8'd5; q_in = 8'd12; mode = MODE_MAG; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; i_in = 8'd99; mode = MODE_POWER;
        @(negedge clk);
        in_valid = 1'b0;
        chk("drop_set", 32'(drop_flag), 1);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(6, lat);
        chk("drop_lat", lat, mag_lat(W));
        chk("drop_data", 32'(out_data), 13);
        count_out(15, cnt);
        chk("drop_single", cnt, 0);
        chk("drop_sticky", 32'(drop_flag), 1);
        drop_clr = 1'b1;
        @(negedge clk);
        drop_clr = 1'b0;
        chk("drop_clr", 32'(drop_flag), 0);

        // Clear coincident with a fresh drop: set wins
        @(negedge clk);
        i_in = 8'd1; q_in = 8'd1; mode = MODE_MAG; in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("drop_again", 32'(drop_flag), 1);
        drop_clr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; drop_clr = 1'b0;
        chk("drop_win", 32'(drop_flag), 1);
        wait_out(3, lat);
        chk("drop2_lat", lat, mag_lat(W));
        chk("drop2_data", 32'(out_data), 1);

        // Reset seven cycles into a magnitude computation
        @(negedge clk);
        i_in = 8'd10; q_in = 8'd20; mode = MODE_MAG; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_ready", 32'(in_ready), 1);
        chk("mid_valid", 32'(out_valid), 0);
        chk("mid_data", 32'(out_data), 0);
        chk("mid_drop", 32'(drop_flag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_out(20, cnt);
        chk("mid_none", cnt, 0);
        run("after_rst", 6, 8, MODE_MAG, 10, mag_lat(W));

        // Back-to-back power stream with in_valid held high
        k = 1; acc = 0; last_acc = -1; got = 0; took = 1'b0;
        @(negedge clk);
        i_in = W'(k * 13 - 40); q_in = W'(50 - k * 7); mode = MODE_POWER; in_valid = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
            if (took) begin
                if (acc < 5) begin
                    k++;
                    i_in = W'(k * 13 - 40);
                    q_in = W'(50 - k * 7);
                end else begin
                    in_valid = 1'b0;
                end
            end
            took = 1'b0;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) chk("b2b_extra", 32'(out_valid), 0);
                else begin
                    chk("b2b_data", 32'(out_data), exp_q.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    chk("b2b_gap", cyc - last_acc, POWER_LAT);
                    chk("b2b_on_done", 32'(out_valid), 1);
                end
                ii = $signed(i_in);
                qq = $signed(q_in);
                exp_q.push_back(ii * ii + qq * qq);
                last_acc = cyc;
                acc++;
                took = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("b2b_count", got, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
